// File: rtl/axi_burst_mem_slave.sv
// rtl/axi_burst_mem_slave.sv - AXI-like burst memory responder with stall-driven backpressure
// Independent write (AW/W/B) and read (AR/R) FSMs sharing one word-addressed memory array.
module axi_burst_mem_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int BRESP_DELAY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic              rlast,
  input  logic              stall_aw,
  input  logic              stall_w,
  input  logic              stall_ar
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // With no response delay the wait state is skipped so bvalid follows the wlast beat directly.
  localparam w_state_t   W_AFTER_LAST = (BRESP_DELAY == 0) ? W_RESP : W_WAIT;
  localparam logic [3:0] DLY_LOAD     = 4'((BRESP_DELAY > 0) ? BRESP_DELAY - 1 : 0);

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic [PTR_W-1:0]  wptr, wptr_next;
  logic [PTR_W-1:0]  rptr, rptr_next;
  logic [PTR_W-1:0]  mem_waddr;
  logic              mem_we;
  logic [3:0]        dcnt, dcnt_next;
  logic [7:0]        rcnt, rcnt_next;
  logic [PTR_W-1:0]  aw_idx;
  logic [PTR_W-1:0]  ar_idx;

  assign aw_idx = awaddr[PTR_W-1:0];
  assign ar_idx = araddr[PTR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      wptr    <= '0;
      rptr    <= '0;
      dcnt    <= '0;
      rcnt    <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      wptr    <= wptr_next;
      rptr    <= rptr_next;
      dcnt    <= dcnt_next;
      rcnt    <= rcnt_next;
    end
  end

  // Storage is deliberately not reset so words written before an aborted burst survive.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= wdata;
    end
  end

  always_comb begin
    w_next    = w_state;
    wptr_next = wptr;
    dcnt_next = dcnt;
    mem_we    = 1'b0;
    mem_waddr = wptr;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = !stall_aw;
        wready  = awvalid && !stall_aw && !stall_w;
        if (awvalid && awready) begin
          wptr_next = aw_idx;
          w_next    = W_DATA;
          if (wvalid && wready) begin
            mem_we    = 1'b1;
            mem_waddr = aw_idx;
            wptr_next = aw_idx + PTR_W'(1);
            if (wlast) begin
              w_next    = W_AFTER_LAST;
              dcnt_next = DLY_LOAD;
            end
          end
        end
      end
      W_DATA: begin
        wready = !stall_w;
        if (wvalid && wready) begin
          mem_we    = 1'b1;
          wptr_next = wptr + PTR_W'(1);
          if (wlast) begin
            w_next    = W_AFTER_LAST;
            dcnt_next = DLY_LOAD;
          end
        end
      end
      W_WAIT: begin
        if (dcnt == 4'd0) begin
          w_next = W_RESP;
        end else begin
          dcnt_next = dcnt - 4'd1;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
    if (rst) begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_comb begin
    r_next    = r_state;
    rptr_next = rptr;
    rcnt_next = rcnt;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rdata     = '0;
    case (r_state)
      R_IDLE: begin
        arready = !stall_ar;
        if (arvalid && arready) begin
          rptr_next = ar_idx;
          rcnt_next = arlen;
          r_next    = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (rcnt == 8'd0);
        rdata  = mem[rptr];
        if (rready) begin
          if (rlast) begin
            r_next = R_IDLE;
          end else begin
            rptr_next = rptr + PTR_W'(1);
            rcnt_next = rcnt - 8'd1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
    if (rst) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rdata   = '0;
    end
  end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb/tb_axi_burst_mem_slave.sv - directed bench for axi_burst_mem_slave
// Two instances share stimulus: d0 uses BRESP_DELAY=0, d3 uses BRESP_DELAY=3.
module tb_axi_burst_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic        stall_aw, stall_w, stall_ar;
  logic [7:0]  awaddr, araddr, arlen;
  logic [31:0] wdata;

  logic        d0_awready, d0_wready, d0_bvalid, d0_arready, d0_rvalid, d0_rlast;
  logic [31:0] d0_rdata;
  logic        d3_awready, d3_wready, d3_bvalid, d3_arready, d3_rvalid, d3_rlast;
  logic [31:0] d3_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_burst_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .BRESP_DELAY(0)) d0 (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(d0_awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(d0_wready), .wdata(wdata), .wlast(wlast),
    .bvalid(d0_bvalid), .bready(bready),
    .arvalid(arvalid), .arready(d0_arready), .araddr(araddr), .arlen(arlen),
    .rvalid(d0_rvalid), .rready(rready), .rdata(d0_rdata), .rlast(d0_rlast),
    .stall_aw(stall_aw), .stall_w(stall_w), .stall_ar(stall_ar)
  );

  axi_burst_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .BRESP_DELAY(3)) d3 (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(d3_awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(d3_wready), .wdata(wdata), .wlast(wlast),
    .bvalid(d3_bvalid), .bready(bready),
    .arvalid(arvalid), .arready(d3_arready), .araddr(araddr), .arlen(arlen),
    .rvalid(d3_rvalid), .rready(rready), .rdata(d3_rdata), .rlast(d3_rlast),
    .stall_aw(stall_aw), .stall_w(stall_w), .stall_ar(stall_ar)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    stall_aw = 0; stall_w = 0; stall_ar = 0;
    awaddr = 0; araddr = 0; arlen = 0; wdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    step(); step();
    #1;
    checks++;
    if ({d0_awready, d0_wready, d0_bvalid, d0_arready, d0_rvalid, d0_rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl_d0 got %b exp 000000", {d0_awready, d0_wready, d0_bvalid, d0_arready, d0_rvalid, d0_rlast});
    end
    checks++;
    if (d0_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h exp 00000000", d0_rdata);
    end
    checks++;
    if ({d3_awready, d3_wready, d3_bvalid, d3_arready, d3_rvalid, d3_rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl_d3 got %b exp 000000", {d3_awready, d3_wready, d3_bvalid, d3_arready, d3_rvalid, d3_rlast});
    end
    rst = 0;
    idle_inputs();
    #1;
    checks++;
    if ({d0_awready, d0_arready, d0_wready} !== 3'b110) begin
      errors++; $display("FAIL idle_ready got %b exp 110", {d0_awready, d0_arready, d0_wready});
    end
    step();
  endtask

  task automatic test_single();
    awvalid = 1; awaddr = 8'h10; wvalid = 1; wdata = 32'hA5A5A5A5; wlast = 1;
    #1;
    checks++;
    if ({d0_awready, d0_wready} !== 2'b11) begin
      errors++; $display("FAIL single_aw_w_ready got %b exp 11", {d0_awready, d0_wready});
    end
    step();
    awvalid = 0; wvalid = 0; wlast = 0;
    #1;
    checks++;
    if (d0_bvalid !== 1'b1) begin
      errors++; $display("FAIL single_bvalid got %b exp 1", d0_bvalid);
    end
    bready = 1;
    step();
    bready = 0;
    #1;
    checks++;
    if ({d0_bvalid, d0_awready} !== 2'b01) begin
      errors++; $display("FAIL single_after_b got %b exp 01", {d0_bvalid, d0_awready});
    end
    arvalid = 1; araddr = 8'h10; arlen = 0;
    #1;
    checks++;
    if (d0_arready !== 1'b1) begin
      errors++; $display("FAIL single_arready got %b exp 1", d0_arready);
    end
    step();
    arvalid = 0;
    #1;
    checks++;
    if ({d0_rvalid, d0_rlast, d0_rdata} !== {2'b11, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL single_read got %b %b %h exp 1 1 a5a5a5a5", d0_rvalid, d0_rlast, d0_rdata);
    end
    rready = 1;
    step();
    rready = 0;
    #1;
    checks++;
    if (d0_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_r_done got %b exp 0", d0_rvalid);
    end
  endtask

  task automatic test_burst();
    awvalid = 1; awaddr = 8'h20; wvalid = 0;
    #1;
    checks++;
    if ({d0_awready, d0_wready} !== 2'b11) begin
      errors++; $display("FAIL burst_aw got %b exp 11", {d0_awready, d0_wready});
    end
    step();
    awvalid = 0;
    for (int i = 1; i <= 4; i++) begin
      wvalid = 1; wdata = 32'(i); wlast = (i == 4);
      #1;
      checks++;
      if (d0_wready !== 1'b1) begin
        errors++; $display("FAIL burst_wready beat %0d got %b exp 1", i, d0_wready);
      end
      step();
    end
    wvalid = 0; wlast = 0;
    #1;
    checks++;
    if (d0_bvalid !== 1'b1) begin
      errors++; $display("FAIL burst_bvalid got %b exp 1", d0_bvalid);
    end
    bready = 1;
    step();
    bready = 0;
    arvalid = 1; araddr = 8'h20; arlen = 3;
    step();
    arvalid = 0; rready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({d0_rvalid, d0_rlast, d0_rdata} !== {1'b1, (i == 3), 32'(i + 1)}) begin
        errors++;
        $display("FAIL burst_read beat %0d got %b %b %h exp 1 %b %h", i, d0_rvalid, d0_rlast, d0_rdata, (i == 3), 32'(i + 1));
      end
      step();
    end
    rready = 0;
    #1;
    checks++;
    if (d0_rvalid !== 1'b0) begin
      errors++; $display("FAIL burst_r_done got %b exp 0", d0_rvalid);
    end
  endtask

  task automatic test_backpressure();
    stall_aw = 1; awvalid = 1; awaddr = 8'h30;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({d0_awready, d0_wready} !== 2'b00) begin
        errors++; $display("FAIL bp_awready cycle %0d got %b exp 00", i, {d0_awready, d0_wready});
      end
      step();
    end
    stall_aw = 0;
    #1;
    checks++;
    if (d0_awready !== 1'b1) begin
      errors++; $display("FAIL bp_aw_release got %b exp 1", d0_awready);
    end
    step();
    awvalid = 0;
    stall_w = 1; wvalid = 1; wdata = 32'h11; wlast = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (d0_wready !== 1'b0) begin
        errors++; $display("FAIL bp_wready cycle %0d got %b exp 0", i, d0_wready);
      end
      step();
    end
    stall_w = 0;
    #1;
    checks++;
    if (d0_wready !== 1'b1) begin
      errors++; $display("FAIL bp_w_release got %b exp 1", d0_wready);
    end
    step();
    wdata = 32'h22; wlast = 1;
    step();
    wvalid = 0; wlast = 0; bready = 1;
    #1;
    checks++;
    if (d0_bvalid !== 1'b1) begin
      errors++; $display("FAIL bp_bvalid got %b exp 1", d0_bvalid);
    end
    step();
    bready = 0;
    stall_ar = 1; arvalid = 1; araddr = 8'h30; arlen = 1;
    #1;
    checks++;
    if (d0_arready !== 1'b0) begin
      errors++; $display("FAIL bp_arready got %b exp 0", d0_arready);
    end
    step();
    stall_ar = 0;
    step();
    arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({d0_rvalid, d0_rlast, d0_rdata} !== {2'b10, 32'h11}) begin
        errors++; $display("FAIL bp_r_hold cycle %0d got %b %b %h exp 1 0 00000011", i, d0_rvalid, d0_rlast, d0_rdata);
      end
      step();
    end
    rready = 1;
    step();
    #1;
    checks++;
    if ({d0_rvalid, d0_rlast, d0_rdata} !== {2'b11, 32'h22}) begin
      errors++; $display("FAIL bp_r_beat2 got %b %b %h exp 1 1 00000022", d0_rvalid, d0_rlast, d0_rdata);
    end
    step();
    rready = 0;
  endtask

  task automatic test_wrap();
    awvalid = 1; awaddr = 8'hFF; wvalid = 1; wdata = 32'hDEAD0001; wlast = 0;
    step();
    awvalid = 0; wdata = 32'hDEAD0002; wlast = 1;
    step();
    wvalid = 0; wlast = 0; bready = 1;
    step();
    bready = 0;
    arvalid = 1; araddr = 8'hFF; arlen = 1;
    step();
    arvalid = 0;
    #1;
    checks++;
    if ({d0_rlast, d0_rdata} !== {1'b0, 32'hDEAD0001}) begin
      errors++; $display("FAIL wrap_ff got %b %h exp 0 dead0001", d0_rlast, d0_rdata);
    end
    rready = 1;
    step();
    #1;
    checks++;
    if ({d0_rlast, d0_rdata} !== {1'b1, 32'hDEAD0002}) begin
      errors++; $display("FAIL wrap_00 got %b %h exp 1 dead0002", d0_rlast, d0_rdata);
    end
    step();
    rready = 0;
    arvalid = 1; araddr = 8'h00; arlen = 0;
    step();
    arvalid = 0;
    #1;
    checks++;
    if (d0_rdata !== 32'hDEAD0002) begin
      errors++; $display("FAIL wrap_addr0 got %h exp dead0002", d0_rdata);
    end
    rready = 1;
    step();
    rready = 0;
  endtask

  task automatic test_reset_mid();
    awvalid = 1; awaddr = 8'h40; wvalid = 1; wdata = 32'h55; wlast = 0;
    step();
    awvalid = 0; wdata = 32'h66;
    step();
    wdata = 32'h67;
    rst = 1;
    #1;
    checks++;
    if ({d0_awready, d0_wready, d0_bvalid, d0_arready, d0_rvalid, d0_rlast} !== 6'b0) begin
      errors++; $display("FAIL rstmid_outputs got %b exp 000000", {d0_awready, d0_wready, d0_bvalid, d0_arready, d0_rvalid, d0_rlast});
    end
    step();
    rst = 0; wvalid = 0;
    #1;
    checks++;
    if ({d0_awready, d0_bvalid} !== 2'b10) begin
      errors++; $display("FAIL rstmid_idle got %b exp 10", {d0_awready, d0_bvalid});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (d0_bvalid !== 1'b0) begin
        errors++; $display("FAIL rstmid_no_b cycle %0d got %b exp 0", i, d0_bvalid);
      end
    end
    awvalid = 1; awaddr = 8'h50; wvalid = 1; wdata = 32'h77; wlast = 1;
    #1;
    checks++;
    if ({d0_awready, d0_wready} !== 2'b11) begin
      errors++; $display("FAIL rstmid_new_aw got %b exp 11", {d0_awready, d0_wready});
    end
    step();
    awvalid = 0; wvalid = 0; wlast = 0; bready = 1;
    #1;
    checks++;
    if (d0_bvalid !== 1'b1) begin
      errors++; $display("FAIL rstmid_new_b got %b exp 1", d0_bvalid);
    end
    step();
    bready = 0;
    arvalid = 1; araddr = 8'h40; arlen = 1;
    step();
    arvalid = 0; rready = 1;
    #1;
    checks++;
    if (d0_rdata !== 32'h55) begin
      errors++; $display("FAIL rstmid_kept0 got %h exp 00000055", d0_rdata);
    end
    step();
    #1;
    checks++;
    if ({d0_rlast, d0_rdata} !== {1'b1, 32'h66}) begin
      errors++; $display("FAIL rstmid_kept1 got %b %h exp 1 00000066", d0_rlast, d0_rdata);
    end
    step();
    rready = 0;
  endtask

  task automatic test_bresp_delay();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    awvalid = 1; awaddr = 8'h60; wvalid = 1; wdata = 32'h99; wlast = 1;
    #1;
    checks++;
    if ({d3_awready, d3_wready} !== 2'b11) begin
      errors++; $display("FAIL dly_aw got %b exp 11", {d3_awready, d3_wready});
    end
    step();
    awvalid = 0; wvalid = 0; wlast = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (d3_bvalid !== 1'b0) begin
        errors++; $display("FAIL dly_wait cycle %0d got %b exp 0", i, d3_bvalid);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({d3_bvalid, d3_awready} !== 2'b10) begin
        errors++; $display("FAIL dly_bhold cycle %0d got %b exp 10", i, {d3_bvalid, d3_awready});
      end
      if (i == 2) bready = 1;
      step();
    end
    bready = 0;
    #1;
    checks++;
    if ({d3_bvalid, d3_awready} !== 2'b01) begin
      errors++; $display("FAIL dly_after_b got %b exp 01", {d3_bvalid, d3_awready});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_bresp_delay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
